core_dma: RTL

- AHB master DMA engine that consumes the read/write address requests of core_set.
- Read phase: for each burst base address, issues one INCR8 word burst and stores 64 words (one 8x8 block) in an internal buffer.
- Write phase: issues 8 write bursts and streams the block back out, reordered by the rotation setting.
- Drives core_set's I_DMA_READY so both blocks advance in lockstep, one pulse per accepted address beat.

---
 rtl/rotate_pkg.sv | 27 ++
 rtl/core_buf.sv | 61 ++++++
 rtl/core_dma.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared encodings for the rotation DMA path: AHB codes, rotation codes,
// DMA FSM states and block geometry.
package rotate_pkg;

  localparam int unsigned BEATS = 8;
  localparam int unsigned DEPTH = BEATS * BEATS;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBurst,
    StDrain,
    StError
  } dma_state_e;

endpackage

// File: rtl/core_buf.sv
// 8x8 block buffer: write port indexed directly, registered read port through
// the rotation remap (enabled by CORE_DMA_ROTBUF_EN, identity otherwise).
module core_buf
  import rotate_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BUF_DEPTH = DEPTH,
  parameter int unsigned IDX_W = $clog2(BUF_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  ridx_i,
  input  logic [1:0]        deg_i,
  input  logic              dir_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  ridx_m;

`ifdef CORE_DMA_ROTBUF_EN
  function automatic logic [5:0] map_idx(logic [5:0] idx, logic [1:0] deg, logic dir);
    logic [2:0] r;
    logic [2:0] c;
    logic [1:0] eff;
    r   = idx[5:3];
    c   = idx[2:0];
    // Counter-clockwise swaps the quarter turns.
    eff = (!dir && deg[0]) ? {~deg[1], deg[0]} : deg;
    unique case (eff)
      DEG_0:   map_idx = {r, c};
      DEG_90:  map_idx = {3'd7 - c, r};
      DEG_180: map_idx = {3'd7 - r, 3'd7 - c};
      default: map_idx = {c, 3'd7 - r};
    endcase
  endfunction

  assign ridx_m = map_idx(ridx_i, deg_i, dir_i);
`else
  logic unused_rot;
  assign unused_rot = ^{deg_i, dir_i};
  assign ridx_m     = ridx_i;
`endif

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[ridx_m];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core_dma.sv
// AHB INCR8 master moving one 8x8 block in/out of core_buf in lockstep with
// core_set; CORE_DMA_ROTBUF_EN selects buffer-side rotation.
module core_dma
  import rotate_pkg::*;
#(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic              I_WRITE,
  input  logic              I_BUSY,
  input  logic              I_DIRECTION,
  input  logic [1:0]        I_DEGREES,
  output logic              O_DMA_READY,
  output logic [ADDR_W-1:0] O_HADDR,
  output logic [1:0]        O_HTRANS,
  output logic              O_HWRITE,
  output logic [2:0]        O_HSIZE,
  output logic [2:0]        O_HBURST,
  output logic [DATA_W-1:0] O_HWDATA,
  input  logic [DATA_W-1:0] I_HRDATA,
  input  logic              I_HREADY,
  input  logic              I_HRESP,
  output logic              O_ERR
);

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned SET_W  = IDX_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  dma_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [SET_W-1:0]  burst_q, burst_d;
  logic              err_q, err_d;
  logic              dvalid_q, dvalid_d;
  logic [IDX_W-1:0]  didx_q, didx_d;
  logic              dwrite_q, dwrite_d;
  logic [ADDR_W-1:0] base_q;
  logic              write_q;
  logic              dir_q;
  logic [1:0]        deg_q;

  logic active;
  logic err_now;
  logic accept;

  assign active  = (state_q == StBurst);
  assign err_now = dvalid_q & I_HRESP;
  assign accept  = active & I_HREADY & ~err_now;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    err_d    = err_q;
    dvalid_d = dvalid_q;
    didx_d   = didx_q;
    dwrite_d = dwrite_q;

    // Address and data phases both stall on HREADY low.
    if (I_HREADY) dvalid_d = accept;
    if (accept) begin
      beat_d   = beat_q + BEAT_W'(1);
      didx_d   = {burst_q, beat_q};
      dwrite_d = write_q;
      if (beat_q == LAST_BEAT) burst_d = burst_q + SET_W'(1);
    end

    unique case (state_q)
      StIdle: if (I_BUSY && !err_q) state_d = StAddr;
      StAddr: begin
        state_d = StBurst;
        beat_d  = '0;
      end
      StBurst: if (accept && beat_q == LAST_BEAT) state_d = StDrain;
      StDrain: if (!(dvalid_q && !I_HREADY)) state_d = I_BUSY ? StAddr : StIdle;
      StError: begin
        beat_d  = '0;
        burst_d = '0;
        if (!I_BUSY) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_now) begin
      state_d  = StError;
      err_d    = 1'b1;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge I_HCLK or posedge I_HRESET) begin
    if (I_HRESET) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      dvalid_q <= 1'b0;
      didx_q   <= '0;
      dwrite_q <= 1'b0;
      base_q   <= '0;
      write_q  <= 1'b0;
      dir_q    <= 1'b0;
      deg_q    <= DEG_0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
      dvalid_q <= dvalid_d;
      didx_q   <= didx_d;
      dwrite_q <= dwrite_d;
      if (state_q == StAddr) begin
        base_q  <= I_ADDR;
        write_q <= I_WRITE;
        dir_q   <= I_DIRECTION;
        deg_q   <= I_DEGREES;
      end
    end
  end

  always_comb begin
    O_HTRANS = HTRANS_IDLE;
    O_HADDR  = '0;
    O_HWRITE = 1'b0;
    O_HSIZE  = 3'b000;
    O_HBURST = 3'b000;
    if (active) begin
      O_HTRANS = (beat_q == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      O_HADDR  = base_q + ADDR_W'({beat_q, 2'b00});
      O_HWRITE = write_q;
      O_HSIZE  = HSIZE_WORD;
      O_HBURST = HBURST_INCR8;
    end
  end

  assign O_DMA_READY = accept;
  assign O_ERR       = err_q;

  core_buf #(
    .DATA_W   (DATA_W),
    .BUF_DEPTH(DEPTH),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clk_i  (I_HCLK),
    .rst_i  (I_HRESET),
    .we_i   (dvalid_q & ~dwrite_q & I_HREADY & ~I_HRESP),
    .widx_i (didx_q),
    .wdata_i(I_HRDATA),
    .re_i   (accept & write_q),
    .ridx_i ({burst_q, beat_q}),
    .deg_i  (deg_q),
    .dir_i  (dir_q),
    .rdata_o(O_HWDATA)
  );

endmodule
